pipe_ctrl: RTL and testbench

- Central pipeline control for the 5-stage core. Generates the stall vector and flush strobes consumed by every stage register (pc, if_id, id_exe, exe_mem, mem_wb, wb).
- Inputs it arbitrates:
  - load-use hazards reported back from id_exe (inst_is_load, rd) together with ID source registers;
  - multi-cycle divide handshake from EXE;
  - data-bus wait from MEM;
  - jump requests from EXE;
  - interrupt requests from the CSR/CLINT block.
- It is the initiator side of the stall/flush protocol whose responders are the stage registers.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_hazard_detect.sv | 25 ++
 rtl/pipe_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared constants for the pipeline control block: stall level encoding,
//   the stall patterns driven onto the stage registers, and the FSM state
//   encodings. Stall vector bit order: [0]=pc [1]=if_id [2]=id_exe
//   [3]=exe_mem [4]=mem_wb [5]=wb.
package pipe_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [5:0] STALL_NONE = {6{NOSTOP}};
    // Freeze pc/if_id/id_exe; id_exe inserts a bubble behind the load.
    localparam logic [5:0] STALL_LOAD = {NOSTOP, NOSTOP, NOSTOP, STOP, STOP, STOP};
    // Freeze everything up to and including exe_mem while the divider runs.
    localparam logic [5:0] STALL_DIV  = {NOSTOP, NOSTOP, STOP, STOP, STOP, STOP};
    // Freeze everything except wb while the data bus is outstanding.
    localparam logic [5:0] STALL_MEM  = {NOSTOP, STOP, STOP, STOP, STOP, STOP};

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DIV_WAIT  = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT  = 2'd2;
    localparam logic [1:0] ST_INT_FLUSH = 2'd3;

    // True when an ID source operand is read and names the given rd.
    function automatic logic reg_match(input logic re,
                                       input logic [4:0] rs,
                                       input logic [4:0] rd);
        return re && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect
//   Purely combinational load-use comparator. Flags when the instruction in
//   EXE is a load whose (non-zero) destination is read by the instruction
//   currently in ID.
//   Inputs : id_rs1_raddr_i/id_rs1_re_i, id_rs2_raddr_i/id_rs2_re_i,
//            exe_inst_is_load_i, exe_rd_i
//   Outputs: load_use_o
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_raddr_i,
    input  logic       id_rs1_re_i,
    input  logic [4:0] id_rs2_raddr_i,
    input  logic       id_rs2_re_i,
    input  logic       exe_inst_is_load_i,
    input  logic [4:0] exe_rd_i,
    output logic       load_use_o
);

    // x0 is never written, so a load to x0 cannot create a hazard.
    assign load_use_o = exe_inst_is_load_i && (exe_rd_i != 5'd0) &&
                        (reg_match(id_rs1_re_i, id_rs1_raddr_i, exe_rd_i) ||
                         reg_match(id_rs2_re_i, id_rs2_raddr_i, exe_rd_i));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Central stall/flush controller for the 5-stage core. Arbitrates memory
//   wait > trap > divide > jump > load-use and drives the stall vector, flush
//   strobes and pc redirect consumed by the stage registers.
//   Inputs : clk_i, rst_i (async, active-high), ID source regs, EXE load info,
//            divide handshake, MEM bus req/ack, jump request/target,
//            interrupt request/vector.
//   Outputs: stall_o[5:0], flush_jump_o, flush_int_o, pc_we_o, pc_waddr_o,
//            int_ack_o, bus_err_o, stall_cnt_o (cycles with any stall).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [4:0]           id_rs1_raddr_i,
    input  logic                 id_rs1_re_i,
    input  logic [4:0]           id_rs2_raddr_i,
    input  logic                 id_rs2_re_i,
    input  logic                 exe_inst_is_load_i,
    input  logic [4:0]           exe_rd_i,
    input  logic                 div_start_i,
    input  logic                 div_done_i,
    input  logic                 mem_req_i,
    input  logic                 mem_ack_i,
    input  logic                 jump_req_i,
    input  logic [31:0]          jump_addr_i,
    input  logic                 int_req_i,
    input  logic [31:0]          int_addr_i,
    output logic [5:0]           stall_o,
    output logic                 flush_jump_o,
    output logic                 flush_int_o,
    output logic                 pc_we_o,
    output logic [31:0]          pc_waddr_o,
    output logic                 int_ack_o,
    output logic                 bus_err_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    localparam int unsigned TW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(BUS_TIMEOUT);

    logic [1:0]           state_q, state_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic        load_use;
    logic        mem_wait_req;
    logic        div_wait_req;
    logic [5:0]  stall_c;
    logic        flush_jump_c;
    logic        flush_int_c;
    logic        pc_we_c;
    logic [31:0] pc_waddr_c;
    logic        int_ack_c;
    logic        bus_err_c;

    hazard_detect u_hazard (
        .id_rs1_raddr_i     (id_rs1_raddr_i),
        .id_rs1_re_i        (id_rs1_re_i),
        .id_rs2_raddr_i     (id_rs2_raddr_i),
        .id_rs2_re_i        (id_rs2_re_i),
        .exe_inst_is_load_i (exe_inst_is_load_i),
        .exe_rd_i           (exe_rd_i),
        .load_use_o         (load_use)
    );

    assign mem_wait_req = mem_req_i && !mem_ack_i;
    // A divide that completes in its start cycle needs no stall.
    assign div_wait_req = div_start_i && !div_done_i;

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        stall_c      = STALL_NONE;
        flush_jump_c = 1'b0;
        flush_int_c  = 1'b0;
        pc_we_c      = 1'b0;
        pc_waddr_c   = '0;
        int_ack_c    = 1'b0;
        bus_err_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_wait_req) begin
                    stall_c = STALL_MEM;
                    tmo_d   = '0;
                    state_d = ST_MEM_WAIT;
                end else if (int_req_i) begin
                    // The trap itself is taken in INT_FLUSH; this cycle only
                    // suppresses lower-priority events.
                    state_d = ST_INT_FLUSH;
                end else if (div_wait_req) begin
                    stall_c = STALL_DIV;
                    state_d = ST_DIV_WAIT;
                end else if (jump_req_i) begin
                    flush_jump_c = 1'b1;
                    pc_we_c      = 1'b1;
                    pc_waddr_c   = jump_addr_i;
                end else if (load_use) begin
                    stall_c = STALL_LOAD;
                end
            end
            ST_DIV_WAIT: begin
                stall_c = STALL_DIV;
                if (div_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_WAIT: begin
                stall_c = STALL_MEM;
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_MAX) begin
                    // Counter holds at its limit; the abort leaves the state.
                    bus_err_c = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_INT_FLUSH: begin
                flush_int_c = 1'b1;
                pc_we_c     = 1'b1;
                pc_waddr_c  = int_addr_i;
                int_ack_c   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of inputs.
    assign stall_o      = rst_i ? STALL_NONE : stall_c;
    assign flush_jump_o = !rst_i && flush_jump_c;
    assign flush_int_o  = !rst_i && flush_int_c;
    assign pc_we_o      = !rst_i && pc_we_c;
    assign pc_waddr_o   = rst_i ? '0 : pc_waddr_c;
    assign int_ack_o    = !rst_i && int_ack_c;
    assign bus_err_o    = !rst_i && bus_err_c;

    assign stall_cnt_d = (stall_o != STALL_NONE) ? stall_cnt_q + CNT_WIDTH'(1)
                                                 : stall_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    typedef struct packed {
        logic        rst;
        logic [4:0]  rs1;
        logic        rs1_re;
        logic [4:0]  rs2;
        logic        rs2_re;
        logic        ld;
        logic [4:0]  rd;
        logic        ds;
        logic        dd;
        logic        mr;
        logic        ma;
        logic        jr;
        logic [31:0] ja;
        logic        ir;
        logic [31:0] ia;
    } in_t;

    typedef struct packed {
        logic [5:0]  stall;
        logic        fj;
        logic        fi;
        logic        pw;
        logic [31:0] pa;
        logic        ack;
        logic        be;
    } exp_t;

    typedef struct packed {
        exp_t        e;
        logic [31:0] cnt;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        rs1_re = 1'b0, rs2_re = 1'b0, ld = 1'b0;
    logic        ds = 1'b0, dd = 1'b0, mr = 1'b0, ma = 1'b0, jr = 1'b0, ir = 1'b0;
    logic [31:0] ja = '0, ia = '0;

    logic [5:0]  stall;
    logic        fj, fi, pw, iack, berr;
    logic [31:0] pa;
    logic [31:0] cnt;

    sb_t         sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_cnt = '0;

    always #5 clk = ~clk;

    pipe_ctrl #(.BUS_TIMEOUT(8), .CNT_WIDTH(32)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .id_rs1_raddr_i     (rs1),
        .id_rs1_re_i        (rs1_re),
        .id_rs2_raddr_i     (rs2),
        .id_rs2_re_i        (rs2_re),
        .exe_inst_is_load_i (ld),
        .exe_rd_i           (rd),
        .div_start_i        (ds),
        .div_done_i         (dd),
        .mem_req_i          (mr),
        .mem_ack_i          (ma),
        .jump_req_i         (jr),
        .jump_addr_i        (ja),
        .int_req_i          (ir),
        .int_addr_i         (ia),
        .stall_o            (stall),
        .flush_jump_o       (fj),
        .flush_int_o        (fi),
        .pc_we_o            (pw),
        .pc_waddr_o         (pa),
        .int_ack_o          (iack),
        .bus_err_o          (berr),
        .stall_cnt_o        (cnt)
    );

    function automatic exp_t mk(input logic [5:0] s, input logic fj_e, input logic fi_e,
                                input logic pw_e, input logic [31:0] pa_e,
                                input logic ack_e, input logic be_e);
        exp_t e;
        e.stall = s; e.fj = fj_e; e.fi = fi_e; e.pw = pw_e;
        e.pa = pa_e; e.ack = ack_e; e.be = be_e;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Driver: apply one cycle of inputs and queue the response expected for it.
    task automatic step(input in_t v, input exp_t e);
        sb_t s;
        @(posedge clk);
        #1;
        rst = v.rst; rs1 = v.rs1; rs1_re = v.rs1_re; rs2 = v.rs2; rs2_re = v.rs2_re;
        ld = v.ld; rd = v.rd; ds = v.ds; dd = v.dd; mr = v.mr; ma = v.ma;
        jr = v.jr; ja = v.ja; ir = v.ir; ia = v.ia;
        if (v.rst) exp_cnt = '0;
        s.e = e;
        s.cnt = exp_cnt;
        sb_q.push_back(s);
        if (!v.rst && e.stall != 6'b0) exp_cnt = exp_cnt + 32'd1;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t s;
            s = sb_q.pop_front();
            chk("stall_o",      {26'd0, stall}, {26'd0, s.e.stall});
            chk("flush_jump_o", {31'd0, fj},    {31'd0, s.e.fj});
            chk("flush_int_o",  {31'd0, fi},    {31'd0, s.e.fi});
            chk("pc_we_o",      {31'd0, pw},    {31'd0, s.e.pw});
            if (s.e.pw || rst) chk("pc_waddr_o", pa, s.e.pa);
            chk("int_ack_o",    {31'd0, iack},  {31'd0, s.e.ack});
            chk("bus_err_o",    {31'd0, berr},  {31'd0, s.e.be});
            chk("stall_cnt_o",  cnt,            s.cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [5:0] S0 = 6'b000000;
    localparam logic [5:0] SL = 6'b000111;
    localparam logic [5:0] SD = 6'b001111;
    localparam logic [5:0] SM = 6'b011111;

    initial begin
        in_t  v;
        exp_t z;
        z = mk(S0, 0, 0, 0, 32'h0, 0, 0);

        // Reset: outputs quiet even with a load-use pattern on the inputs.
        v = '0; v.rst = 1; v.ld = 1; v.rd = 5'd5; v.rs1 = 5'd5; v.rs1_re = 1; v.jr = 1; v.ja = 32'h1234;
        step(v, z);
        v = '0; v.rst = 1; step(v, z);
        v = '0; step(v, z);

        // Load-use on rs1: one bubble cycle, then clear.
        v = '0; v.ld = 1; v.rd = 5'd5; v.rs1 = 5'd5; v.rs1_re = 1; step(v, mk(SL, 0, 0, 0, 0, 0, 0));
        v = '0; v.rs1 = 5'd5; v.rs1_re = 1; step(v, z);
        // Load to x0: no hazard.
        v = '0; v.ld = 1; v.rd = 5'd0; v.rs1 = 5'd0; v.rs1_re = 1; step(v, z);
        // Load-use on rs2, then same match with rs2 not read.
        v = '0; v.ld = 1; v.rd = 5'd9; v.rs2 = 5'd9; v.rs2_re = 1; step(v, mk(SL, 0, 0, 0, 0, 0, 0));
        v = '0; v.ld = 1; v.rd = 5'd9; v.rs2 = 5'd9; v.rs2_re = 0; step(v, z);

        // Divide: start, done 4 cycles later -> 5 stalled cycles.
        v = '0; v.ds = 1; step(v, mk(SD, 0, 0, 0, 0, 0, 0));
        v = '0; for (int i = 0; i < 3; i++) step(v, mk(SD, 0, 0, 0, 0, 0, 0));
        v = '0; v.dd = 1; step(v, mk(SD, 0, 0, 0, 0, 0, 0));
        v = '0; step(v, z);
        // Zero-latency divide.
        v = '0; v.ds = 1; v.dd = 1; step(v, z);
        v = '0; step(v, z);

        // Jump beats a concurrent load-use.
        v = '0; v.jr = 1; v.ja = 32'h8000_0040; v.ld = 1; v.rd = 5'd5; v.rs1 = 5'd5; v.rs1_re = 1;
        step(v, mk(S0, 1, 0, 1, 32'h8000_0040, 0, 0));
        v = '0; step(v, z);

        // Divide beats jump; held jump is taken once back in IDLE.
        v = '0; v.ds = 1; v.jr = 1; v.ja = 32'h0000_2000; step(v, mk(SD, 0, 0, 0, 0, 0, 0));
        v = '0; v.dd = 1; v.jr = 1; v.ja = 32'h0000_2000; step(v, mk(SD, 0, 0, 0, 0, 0, 0));
        v = '0; v.jr = 1; v.ja = 32'h0000_2000; step(v, mk(S0, 1, 0, 1, 32'h0000_2000, 0, 0));
        v = '0; step(v, z);

        // Interrupt raised during a memory wait is deferred until after it.
        v = '0; v.mr = 1; v.ia = 32'h8000_0100; step(v, mk(SM, 0, 0, 0, 0, 0, 0));
        v.ir = 1; step(v, mk(SM, 0, 0, 0, 0, 0, 0));
        step(v, mk(SM, 0, 0, 0, 0, 0, 0));
        v.ma = 1; step(v, mk(SM, 0, 0, 0, 0, 0, 0));
        v.mr = 0; v.ma = 0; step(v, z);
        step(v, mk(S0, 0, 1, 1, 32'h8000_0100, 1, 0));
        v = '0; step(v, z);

        // Trap beats jump in IDLE.
        v = '0; v.ir = 1; v.ia = 32'h0000_0800; v.jr = 1; v.ja = 32'h0000_0400; step(v, z);
        v.jr = 0; step(v, mk(S0, 0, 1, 1, 32'h0000_0800, 1, 0));
        v = '0; step(v, z);

        // Memory request acked in the same cycle: no wait.
        v = '0; v.mr = 1; v.ma = 1; step(v, z);
        v = '0; step(v, z);

        // Bus timeout (BUS_TIMEOUT=8): entry cycle + 9 wait cycles, error on the last.
        v = '0; v.mr = 1;
        for (int i = 0; i < 9; i++) step(v, mk(SM, 0, 0, 0, 0, 0, 0));
        step(v, mk(SM, 0, 0, 0, 0, 0, 1));
        v = '0; step(v, z);

        // Async reset in the middle of DIV_WAIT.
        v = '0; v.ds = 1; step(v, mk(SD, 0, 0, 0, 0, 0, 0));
        v = '0; step(v, mk(SD, 0, 0, 0, 0, 0, 0));
        v = '0; v.rst = 1; step(v, z);
        // After release the FSM is in IDLE: a load-use gives the load pattern.
        v = '0; v.ld = 1; v.rd = 5'd3; v.rs1 = 5'd3; v.rs1_re = 1; step(v, mk(SL, 0, 0, 0, 0, 0, 0));
        v = '0; step(v, z);

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
